game_ctrl: RTL and testbench

Parametrised game-flow controller for the VGA asteroid game. Replaces the inline title/play/game-over logic in the top level with a standalone block that supports:
- N object channels
- a configurable life count
- edge-qualified collisions followed by a timed invulnerability window
- saturating multi-channel score accumulation
- win/lose outcome reporting

It sits between the object/ship/score sprite modules and the pixel colour mux.

---
 rtl/game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_game_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: title/play/invuln/over game flow for the asteroid game.
// Macro HIGH_SCORE_EN adds a best-score register on o hi_score.
module game_ctrl #(
  parameter int NUM_OBJ       = 5,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 9,
  parameter int WIN_SCORE     = 255,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_BIT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic               frame_tick,
  input  logic [3:0]         btn,
  input  logic [NUM_OBJ-1:0] collision,
  input  logic [NUM_OBJ-1:0] score_inc,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               won,
  output logic               obj_rst,
  output logic               move_en,
  output logic               ship_visible,
  output logic [SCORE_W-1:0] hi_score
);

  typedef enum logic [1:0] {
    S_TITLE  = 2'd0,
    S_PLAY   = 2'd1,
    S_INVULN = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam int SUM_W = SCORE_W + 5;
  localparam logic [SUM_W-1:0] SUM_MAX =
    {5'd0, {SCORE_W{1'b1}}};
  localparam logic [SUM_W-1:0] SUM_WIN =
    SUM_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX =
    {SCORE_W{1'b1}};
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] INV_INIT   = 8'(INVULN_FRAMES);

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic               r_won;
  logic               r_obj_rst;
  logic [3:0]         r_btn_q;
  logic [NUM_OBJ-1:0] r_col_q;
  logic [7:0]         r_inv_cnt;

  state_t             w_state_nx;
  logic [SCORE_W-1:0] w_score_nx;
  logic [2:0]         w_lives_nx;
  logic               w_won_nx;
  logic [7:0]         w_inv_nx;
  logic [SUM_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_score_sat;
  logic               w_win;
  logic               w_btn_rise;
  logic               w_col_new;

  // Score plus the number of objects scoring this cycle.
  always_comb begin
    w_sum = {5'd0, r_score};
    for (int i = 0; i < NUM_OBJ; i++)
      w_sum = w_sum + SUM_W'(score_inc[i]);
  end

  assign w_score_sat = (w_sum > SUM_MAX) ? SCORE_MAX
                                         : w_sum[SCORE_W-1:0];
  assign w_win      = (w_sum >= SUM_WIN);
  assign w_btn_rise = |(btn & ~r_btn_q);
  assign w_col_new  = |(collision & ~r_col_q);

  // Next-state decode: win beats collision; invuln ignores hits.
  always_comb begin
    w_state_nx = r_state;
    w_score_nx = r_score;
    w_lives_nx = r_lives;
    w_won_nx   = r_won;
    w_inv_nx   = r_inv_cnt;
    unique case (r_state)
      S_TITLE: begin
        w_score_nx = '0;
        if (w_btn_rise) begin
          w_state_nx = S_PLAY;
          w_lives_nx = LIVES_INIT;
          w_won_nx   = 1'b0;
        end
      end
      S_PLAY: begin
        w_score_nx = w_score_sat;
        if (w_win) begin
          w_state_nx = S_OVER;
          w_won_nx   = 1'b1;
        end else if (w_col_new) begin
          w_lives_nx = r_lives - 3'd1;
          if (r_lives == 3'd1) begin
            w_state_nx = S_OVER;
            w_won_nx   = 1'b0;
          end else begin
            w_state_nx = S_INVULN;
            w_inv_nx   = INV_INIT;
          end
        end
      end
      S_INVULN: begin
        w_score_nx = w_score_sat;
        if (w_win) begin
          w_state_nx = S_OVER;
          w_won_nx   = 1'b1;
        end else if (frame_tick) begin
          w_inv_nx = r_inv_cnt - 8'd1;
          if (r_inv_cnt <= 8'd1)
            w_state_nx = S_PLAY;
        end
      end
      S_OVER: begin
        if (btn == 4'b1111)
          w_state_nx = S_TITLE;
      end
      default: w_state_nx = S_TITLE;
    endcase
  end

  // State register; a held button at reset cannot start a game.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_TITLE;
      r_score   <= '0;
      r_lives   <= LIVES_INIT;
      r_won     <= 1'b0;
      r_obj_rst <= 1'b1;
      r_btn_q   <= 4'b1111;
      r_col_q   <= '0;
      r_inv_cnt <= '0;
    end else if (pixpulse) begin
      r_state   <= w_state_nx;
      r_score   <= w_score_nx;
      r_lives   <= w_lives_nx;
      r_won     <= w_won_nx;
      r_inv_cnt <= w_inv_nx;
      r_btn_q   <= btn;
      r_col_q   <= collision;
      r_obj_rst <= (r_state == S_TITLE) ||
                   (r_state == S_OVER);
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_hi;
  logic               w_enter_over;

  assign w_enter_over = (w_state_nx == S_OVER) &&
                        (r_state != S_OVER);

  // Best final score, kept across games until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_hi <= '0;
    else if (pixpulse && w_enter_over &&
             (w_score_nx > r_hi))
      r_hi <= w_score_nx;
  end

  assign hi_score = r_hi;
`else
  assign hi_score = '0;
`endif

  assign state   = r_state;
  assign score   = r_score;
  assign lives   = r_lives;
  assign won     = r_won;
  assign obj_rst = r_obj_rst;
  assign move_en = frame_tick &&
                   ((r_state == S_PLAY) ||
                    (r_state == S_INVULN));
  assign ship_visible = (r_state == S_INVULN) ?
                        r_inv_cnt[BLINK_BIT] : 1'b1;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed game sequences against a rule-level model.
// Honours HIGH_SCORE_EN when the design is built with it.
module tb_game_ctrl;

  localparam int NUM_OBJ = 5;
  localparam int LIVES   = 3;
  localparam int SCORE_W = 9;
  localparam int WIN     = 255;
  localparam int INVF    = 60;
  localparam int BLINK   = 2;
  localparam int MAXS    = (1 << SCORE_W) - 1;
`ifdef HIGH_SCORE_EN
  localparam int HI_BEST = 40;
`else
  localparam int HI_BEST = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               pixpulse = 1'b0;
  logic               frame_tick = 1'b0;
  logic [3:0]         btn = 4'hF;
  logic [NUM_OBJ-1:0] collision = '0;
  logic [NUM_OBJ-1:0] score_inc = '0;
  logic [1:0]         state;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               won;
  logic               obj_rst;
  logic               move_en;
  logic               ship_visible;
  logic [SCORE_W-1:0] hi_score;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int m_state, m_score, m_lives, m_won, m_objrst;
  int m_inv, m_hi;
  logic [3:0]         m_btnq;
  logic [NUM_OBJ-1:0] m_colq;

  game_ctrl #(
    .NUM_OBJ(NUM_OBJ), .LIVES(LIVES), .SCORE_W(SCORE_W),
    .WIN_SCORE(WIN), .INVULN_FRAMES(INVF), .BLINK_BIT(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse),
    .frame_tick(frame_tick), .btn(btn),
    .collision(collision), .score_inc(score_inc),
    .state(state), .score(score), .lives(lives),
    .won(won), .obj_rst(obj_rst), .move_en(move_en),
    .ship_visible(ship_visible), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Game rules applied once per enabled edge.
  always @(posedge clk or posedge rst) begin : model
    int pts;
    int ns;
    bit rise;
    bit coln;
    if (rst) begin
      m_state <= 0; m_score <= 0; m_lives <= LIVES;
      m_won <= 0; m_objrst <= 1; m_inv <= 0; m_hi <= 0;
      m_btnq <= 4'hF; m_colq <= '0;
    end else if (pixpulse) begin
      pts  = $countones(score_inc);
      ns   = m_score + pts;
      if (ns > MAXS) ns = MAXS;
      rise = |(btn & ~m_btnq);
      coln = |(collision & ~m_colq);
      m_btnq   <= btn;
      m_colq   <= collision;
      m_objrst <= (m_state == 0 || m_state == 3) ? 1 : 0;
      case (m_state)
        0: begin
          m_score <= 0;
          if (rise) begin
            m_state <= 1; m_lives <= LIVES; m_won <= 0;
          end
        end
        1, 2: begin
          m_score <= ns;
          if (ns >= WIN) begin
            m_state <= 3; m_won <= 1;
`ifdef HIGH_SCORE_EN
            if (ns > m_hi) m_hi <= ns;
`endif
          end else if (m_state == 1 && coln) begin
            m_lives <= m_lives - 1;
            if (m_lives == 1) begin
              m_state <= 3; m_won <= 0;
`ifdef HIGH_SCORE_EN
              if (ns > m_hi) m_hi <= ns;
`endif
            end else begin
              m_state <= 2; m_inv <= INVF;
            end
          end else if (m_state == 2 && frame_tick) begin
            m_inv <= m_inv - 1;
            if (m_inv == 1) m_state <= 1;
          end
        end
        default: if (btn == 4'hF) m_state <= 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("score", 32'(score), 32'(m_score));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("won", 32'(won), 32'(m_won));
      chk("obj_rst", 32'(obj_rst), 32'(m_objrst));
      chk("hi_score", 32'(hi_score), 32'(m_hi));
      chk("move_en", 32'(move_en),
          32'(frame_tick && (m_state == 1 || m_state == 2)));
      chk("ship_visible", 32'(ship_visible),
          (m_state == 2) ? 32'((m_inv >> BLINK) & 1) : 32'd1);
    end
  end

  task automatic pix(input logic [3:0] b,
                     input logic [NUM_OBJ-1:0] c,
                     input logic [NUM_OBJ-1:0] s,
                     input logic ft);
    btn = b; collision = c; score_inc = s; frame_tick = ft;
    @(posedge clk); @(posedge clk); #1 pixpulse = 1'b1;
    @(posedge clk); #1;
    pixpulse = 1'b0; frame_tick = 1'b0; score_inc = '0;
  endtask

  task automatic frames(input int n);
    repeat (n) pix(4'h0, '0, '0, 1'b1);
  endtask

  task automatic new_game();
    pix(4'hF, '0, '0, 1'b0);
    pix(4'h0, '0, '0, 1'b0);
    pix(4'h8, '0, '0, 1'b0);
  endtask

  task automatic lose_all();
    pix(4'h0, 5'b00001, '0, 1'b0);
    frames(INVF);
    pix(4'h0, 5'b00001, '0, 1'b0);
    frames(INVF);
    pix(4'h0, 5'b00001, '0, 1'b0);
  endtask

  initial begin
    #3 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // held button through reset does not start a game
    repeat (3) pix(4'hF, '0, '0, 1'b0);
    chk("t1_title", 32'(state), 0);
    chk("t1_objrst", 32'(obj_rst), 1);
    pix(4'h0, '0, '0, 1'b0);
    pix(4'h8, '0, '0, 1'b0);
    chk("t1_play", 32'(state), 1);
    chk("t1_lives", 32'(lives), 3);
    chk("t1_objrst_lag", 32'(obj_rst), 1);
    pix(4'h8, '0, '0, 1'b0);
    chk("t1_objrst_low", 32'(obj_rst), 0);

    // long collision costs one life
    for (int i = 0; i < 500; i++) begin
      pix(4'h8, 5'b00100, '0, (i % 4) == 3);
      if (i == 0) begin
        chk("t2_invuln", 32'(state), 2);
        chk("t2_lives", 32'(lives), 2);
        chk("t2_vis", 32'(ship_visible), 1);
      end
    end
    chk("t2_back_play", 32'(state), 1);
    chk("t2_lives_end", 32'(lives), 2);
    pix(4'h0, '0, '0, 1'b0);

    // scoring and exact win
    pix(4'h0, '0, 5'b10101, 1'b0);
    chk("t3_plus3", 32'(score), 3);
    repeat (50) pix(4'h0, '0, 5'b11111, 1'b0);
    chk("t3_253", 32'(score), 253);
    chk("t3_still_play", 32'(state), 1);
    pix(4'h0, '0, 5'b00011, 1'b0);
    chk("t3_over", 32'(state), 3);
    chk("t3_won", 32'(won), 1);
    chk("t3_255", 32'(score), 255);
    pix(4'h0, '0, 5'b11111, 1'b0);
    chk("t3_hold", 32'(score), 255);
    chk("t3_objrst", 32'(obj_rst), 1);

    // all-ones returns to title; fresh press needed
    pix(4'hF, '0, '0, 1'b0);
    chk("t4_title", 32'(state), 0);
    pix(4'hF, '0, '0, 1'b0);
    chk("t4_no_start", 32'(state), 0);
    pix(4'h0, '0, '0, 1'b0);
    pix(4'h2, '0, '0, 1'b0);
    chk("t4_left", 32'(state), 1);
    chk("t4_score0", 32'(score), 0);
    pix(4'h0, 5'b00001, '0, 1'b0);
    chk("t4_hit1", 32'(lives), 2);
    chk("t4_vis60", 32'(ship_visible), 1);
    frames(2);
    chk("t4_vis58", 32'(ship_visible), 0);
    frames(INVF - 3);
    chk("t4_inv_last", 32'(state), 2);
    frames(1);
    chk("t4_inv_done", 32'(state), 1);
    pix(4'h0, 5'b00001, '0, 1'b0);
    chk("t4_hit2", 32'(lives), 1);
    frames(INVF);
    pix(4'h0, 5'b00001, '0, 1'b0);
    chk("t4_dead", 32'(state), 3);
    chk("t4_lives0", 32'(lives), 0);
    chk("t4_lost", 32'(won), 0);
    pix(4'h0, '0, '0, 1'b0);
    chk("t4_objrst", 32'(obj_rst), 1);
    new_game();
    chk("t4_restart", 32'(state), 1);

    // win and collision in the same cycle
    repeat (50) pix(4'h0, '0, 5'b11111, 1'b0);
    chk("t5_250", 32'(score), 250);
    pix(4'h0, 5'b00001, 5'b11111, 1'b0);
    chk("t5_over", 32'(state), 3);
    chk("t5_won", 32'(won), 1);
    chk("t5_lives", 32'(lives), 3);

    // best-score tracking and reset mid-invuln
    new_game();
    repeat (8) pix(4'h0, '0, 5'b11111, 1'b0);
    lose_all();
    chk("t6_over40", 32'(state), 3);
    chk("t6_score40", 32'(score), 40);
    chk("t6_hi40", 32'(hi_score), HI_BEST);
    new_game();
    repeat (5) pix(4'h0, '0, 5'b11111, 1'b0);
    lose_all();
    chk("t6_score25", 32'(score), 25);
    chk("t6_hi_keep", 32'(hi_score), HI_BEST);
    new_game();
    pix(4'h0, 5'b00001, '0, 1'b0);
    frames(3);
    chk("t6_mid_inv", 32'(state), 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_state", 32'(state), 0);
    chk("t6_rst_score", 32'(score), 0);
    chk("t6_rst_lives", 32'(lives), 3);
    chk("t6_rst_won", 32'(won), 0);
    chk("t6_rst_objrst", 32'(obj_rst), 1);
    chk("t6_rst_hi", 32'(hi_score), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pix(4'hF, '0, '0, 1'b0);
    chk("t6_post_rst", 32'(state), 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
